// File: rtl/noc_input_buffer.sv
// Per-inport wormhole flit FIFO: buffers link flits, requests one outport per packet, pops on grant.
// Latency: flit written at edge N is on flit_out after N; a head requests from cycle N+2; flit_rel is registered.
// Backpressure: credit based; a flit offered when full with no same-cycle removal is dropped. Optional INBUF_ERR_CHECK_EN adds a sticky err.
module noc_input_buffer #(
  parameter int P = 7,
  parameter int B = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] flit_in,
  input  logic         flit_in_valid,
  output logic [W-1:0] flit_out,
  output logic         flit_out_valid,
  output logic [P-1:0] outport_req,
  input  logic [P-1:0] grant,
  output logic         flit_rel,
  output logic [B-1:0] occupancy,
  output logic         err
);

  localparam int         ENTRIES = 1 << B;
  localparam logic [B-1:0] DEPTH = '1;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

  logic [W-1:0] mem [ENTRIES];
  logic [B-1:0] wptr;
  logic [B-1:0] rptr;
  logic [B-1:0] count;
  state_t       state;
  logic [P-1:0] route_reg;
  logic         rel_q;

  logic [1:0] front_type;
  logic       nonempty;
  logic       full;
  logic       pop;
  logic       discard;
  logic       rd;
  logic       push;

  // Front of the FIFO is read straight out of storage so a new flit is usable the cycle after it lands.
  assign flit_out   = mem[rptr];
  assign front_type = flit_out[W-1:W-2];
  assign nonempty   = (count != '0);
  assign full       = (count == DEPTH);

  // In REQ the FIFO is never empty, so one expression covers both REQ and ACTIVE.
  assign flit_out_valid = nonempty && ((state == REQ) || (state == ACTIVE));
  assign outport_req    = flit_out_valid ? route_reg : '0;

  // Grant bits outside our own request are ignored by the AND.
  assign pop     = flit_out_valid && (|(grant & outport_req));
  // Headless BODY/TAIL flits (type bit 0 clear) are thrown away while idle.
  assign discard = (state == IDLE) && nonempty && !front_type[0];
  assign rd      = pop || discard;
  // A removal in the same edge frees a slot, so a full buffer can still accept.
  assign push    = flit_in_valid && (!full || rd);

  assign flit_rel  = rel_q;
  assign occupancy = count;

  // Storage write; contents need no reset since count qualifies them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= flit_in;
    end
  end

  // Pointer and occupancy bookkeeping, plus the registered release pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rel_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rel_q <= rd;
    end
  end

  // Wormhole packet tracking: latch the route on a head, hold it until the packet ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      route_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (nonempty && front_type[0]) begin
            route_reg <= flit_out[P-1:0];
            state     <= REQ;
          end
        end
        REQ: begin
          if (pop) begin
            state <= (front_type == T_SINGLE) ? IDLE : ACTIVE;
          end
        end
        ACTIVE: begin
          // TAIL and SINGLE both close the packet; BODY and a stray HEAD are plain data here.
          if (pop && ((front_type == T_TAIL) || (front_type == T_SINGLE))) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INBUF_ERR_CHECK_EN
  logic overflow;
  logic err_q;

  assign overflow = flit_in_valid && full && !rd;
  assign err      = err_q;

  // Sticky protocol error: any dropped or discarded flit latches it until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (overflow || discard) begin
      err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Report each protocol event as it happens.
  always @(posedge clk) begin
    if (!rst && overflow) begin
      $display("%0t %m: overflow, flit dropped (type %b)", $time, flit_in[W-1:W-2]);
    end
    if (!rst && discard) begin
      $display("%0t %m: headless flit discarded (type %b)", $time, front_type);
    end
  end
`endif
`else
  assign err = 1'b0;
`endif

  // Type constants kept for readability of the decode above.
  logic unused_types;
  assign unused_types = ^{T_BODY, T_HEAD};

endmodule
